// File: rtl/reg_file_param_if.sv
// Register file access bundle: write port, two read ports, clear request and busy status.
interface reg_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WN;
    logic [DATA_W-1:0] WD;
    logic [ADDR_W-1:0] RN1;
    logic [ADDR_W-1:0] RN2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              Clear;
    logic              Busy;

    modport master (
        output RegWrite, WN, WD, RN1, RN2, Clear,
        input  RD1, RD2, Busy
    );

    modport slave (
        input  RegWrite, WN, WD, RN1, RN2, Clear,
        output RD1, RD2, Busy
    );
endinterface

// File: rtl/reg_file_param.sv
// Parameterized 2R1W register file (r0 hardwired to 0) with a sequential clear sweep.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto matching reads.
module reg_file_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    reg_file_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic              busy;
    logic              wr_en;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign busy  = (state_q == CLEAR);
    assign wr_en = !busy && bus.RegWrite && (bus.WN != '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        unique case (state_q)
            IDLE: begin
                if (wr_en) regs_d[bus.WN] = bus.WD;
                if (bus.Clear) begin
                    state_d = CLEAR;
                    idx_d   = FIRST;
                end
            end
            CLEAR: begin
                // Held reset parks the sweep at index 1 without touching storage
                if (!rst) regs_d[idx_q] = '0;
                if (idx_q == LAST) state_d = IDLE;
                else idx_d = idx_q + ADDR_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= FIRST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    always_comb begin
        rd1 = regs_q[bus.RN1];
        rd2 = regs_q[bus.RN2];
        if (bus.RN1 == '0) rd1 = '0;
        if (bus.RN2 == '0) rd2 = '0;
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && bus.WN == bus.RN1) rd1 = bus.WD;
        if (wr_en && bus.WN == bus.RN2) rd2 = bus.WD;
`endif
        if (busy) begin
            rd1 = '0;
            rd2 = '0;
        end
    end

    assign bus.RD1  = rd1;
    assign bus.RD2  = rd2;
    assign bus.Busy = busy;
endmodule
